// File: rtl/fan_pwm_controller.sv
// Fan speed controller: debounced next/off buttons drive a 4-state speed FSM whose
// target duty is approached by a per-period ramp feeding a glitch-free registered PWM.
module fan_pwm_controller #(
   parameter int PERIOD          = 1000,
   parameter int CNT_W           = 10,
   parameter int DUTY_LOW        = 250,
   parameter int DUTY_MID        = 500,
   parameter int DUTY_HIGH       = 750,
   parameter int RAMP_STEP       = 50,
   parameter int DEBOUNCE_CYCLES = 10000
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_btn_next,
   input  logic             i_btn_off,
   output logic             o_pwm,
   output logic [1:0]       o_state,
   output logic [CNT_W-1:0] o_duty
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int W1   = CNT_W + 1;

   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
   localparam logic [CNT_W-1:0] T_LOW    = CNT_W'(DUTY_LOW);
   localparam logic [CNT_W-1:0] T_MID    = CNT_W'(DUTY_MID);
   localparam logic [CNT_W-1:0] T_HIGH   = CNT_W'(DUTY_HIGH);
   localparam logic [W1-1:0]    STEP_W   = W1'(RAMP_STEP);

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_LOW  = 2'd1,
      ST_MID  = 2'd2,
      ST_HIGH = 2'd3
   } state_e;

   // Button index 0 = next, 1 = off.
   logic [1:0]      btn_raw_s;
   logic [1:0]      sync1_q, sync2_q;
   logic [1:0]      level_q, level_d;
   logic [1:0]      press_q, press_d;
   logic [DB_W-1:0] db_cnt_q [2];
   logic [DB_W-1:0] db_cnt_d [2];

   state_e          state_q, state_d;
   logic [CNT_W-1:0] target_s;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] duty_q, duty_d;
   logic             off_pend_q, off_pend_d;
   logic             pwm_q, pwm_d;
   logic             boundary_s;

   logic [W1-1:0]    cur_w, tgt_w, up_w, ramp_w;

   assign btn_raw_s = {i_btn_off, i_btn_next};

   // Two-flop synchronizers for both raw buttons.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         sync1_q <= 2'b00;
         sync2_q <= 2'b00;
      end else begin
         sync1_q <= btn_raw_s;
         sync2_q <= sync1_q;
      end
   end

   // Debounce: count consecutive disagreeing cycles, accept the level after the full run.
   always_comb begin
      level_d = level_q;
      press_d = 2'b00;
      for (int i = 0; i < 2; i++) begin
         db_cnt_d[i] = db_cnt_q[i];
         if (sync2_q[i] != level_q[i]) begin
            if (db_cnt_q[i] == DB_LAST) begin
               level_d[i]  = sync2_q[i];
               press_d[i]  = sync2_q[i];
               db_cnt_d[i] = {DB_W{1'b0}};
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
         end else begin
            db_cnt_d[i] = {DB_W{1'b0}};
         end
      end
   end

   // Debounce state and registered one-cycle press pulses.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         level_q <= 2'b00;
         press_q <= 2'b00;
         for (int i = 0; i < 2; i++) begin
            db_cnt_q[i] <= {DB_W{1'b0}};
         end
      end else begin
         level_q <= level_d;
         press_q <= press_d;
         for (int i = 0; i < 2; i++) begin
            db_cnt_q[i] <= db_cnt_d[i];
         end
      end
   end

   // Speed FSM state register.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q <= ST_OFF;
      end else begin
         state_q <= state_d;
      end
   end

   // Speed FSM next state: off press has priority over next press.
   always_comb begin
      state_d = state_q;
      if (press_q[1]) begin
         state_d = ST_OFF;
      end else if (press_q[0]) begin
         case (state_q)
            ST_OFF:  state_d = ST_LOW;
            ST_LOW:  state_d = ST_MID;
            ST_MID:  state_d = ST_HIGH;
            ST_HIGH: state_d = ST_OFF;
            default: state_d = ST_OFF;
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Speed FSM output: target duty for each speed.
   always_comb begin
      target_s = {CNT_W{1'b0}};
      case (state_q)
         ST_OFF:  target_s = {CNT_W{1'b0}};
         ST_LOW:  target_s = T_LOW;
         ST_MID:  target_s = T_MID;
         ST_HIGH: target_s = T_HIGH;
         default: target_s = {CNT_W{1'b0}};
      endcase
   end

   assign boundary_s = (cnt_q == CNT_LAST);
   assign cur_w      = {1'b0, duty_q};
   assign tgt_w      = {1'b0, target_s};
   assign up_w       = cur_w + STEP_W;

   // Ramp toward target in CNT_W+1 bits, saturating at the target in both directions.
   always_comb begin
      ramp_w = cur_w;
      if (cur_w < tgt_w) begin
         if (up_w >= tgt_w) begin
            ramp_w = tgt_w;
         end else begin
            ramp_w = up_w;
         end
      end else if (cur_w > tgt_w) begin
         if (cur_w >= (tgt_w + STEP_W)) begin
            ramp_w = cur_w - STEP_W;
         end else begin
            ramp_w = tgt_w;
         end
      end else begin
         ramp_w = cur_w;
      end
   end

   // Period counter, duty update only at the period boundary, pending off-clear.
   always_comb begin
      cnt_d      = cnt_q + CNT_W'(1);
      duty_d     = duty_q;
      off_pend_d = off_pend_q;
      if (boundary_s) begin
         cnt_d      = {CNT_W{1'b0}};
         off_pend_d = 1'b0;
         if (off_pend_q || press_q[1]) begin
            duty_d = {CNT_W{1'b0}};
         end else begin
            duty_d = CNT_W'(ramp_w);
         end
      end else if (press_q[1]) begin
         off_pend_d = 1'b1;
      end else begin
         off_pend_d = off_pend_q;
      end
      pwm_d = (cnt_q < duty_q);
   end

   // PWM counter, applied duty and registered fan drive.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         cnt_q      <= {CNT_W{1'b0}};
         duty_q     <= {CNT_W{1'b0}};
         off_pend_q <= 1'b0;
         pwm_q      <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         duty_q     <= duty_d;
         off_pend_q <= off_pend_d;
         pwm_q      <= pwm_d;
      end
   end

   assign o_pwm   = pwm_q;
   assign o_state = state_q;
   assign o_duty  = duty_q;

endmodule

// File: tb/tb_fan_pwm_controller.sv
// Bench for fan_pwm_controller: directed scenarios plus random button activity, all
// checked every cycle against a sample-history reference model of the controller.
module tb_fan_pwm_controller;
   localparam int P  = 20;
   localparam int W  = 5;
   localparam int DL = 5;
   localparam int DM = 10;
   localparam int DH = 15;
   localparam int RS = 5;
   localparam int DB = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         bn = 1'b0;
   logic         bo = 1'b0;
   logic         pwm;
   logic [1:0]   st;
   logic [W-1:0] duty;

   int tests = 0;
   int fails = 0;

   // Reference model state.
   bit q_n[$];
   bit q_o[$];
   bit m_lvl_n, m_lvl_o, m_p_n, m_p_o, m_pend, m_pwm;
   int m_st, m_duty, m_cnt;

   fan_pwm_controller #(
      .PERIOD(P), .CNT_W(W), .DUTY_LOW(DL), .DUTY_MID(DM), .DUTY_HIGH(DH),
      .RAMP_STEP(RS), .DEBOUNCE_CYCLES(DB)
   ) dut (
      .i_clk(clk), .i_reset(rst_n), .i_btn_next(bn), .i_btn_off(bo),
      .o_pwm(pwm), .o_state(st), .o_duty(duty)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // True when the last DB synchronized samples (raw delayed two edges) all differ from lvl.
   function automatic bit window_flip(input bit q[$], input bit lvl);
      int e = q.size() - 1;
      for (int k = 0; k < DB; k++) begin
         int  i = e - 2 - k;
         bit  s = (i < 0) ? 1'b0 : q[i];
         if (s == lvl) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic int tgt_of(input int s);
      case (s)
         1:       return DL;
         2:       return DM;
         3:       return DH;
         default: return 0;
      endcase
   endfunction

   task automatic model_reset();
      q_n.delete();
      q_o.delete();
      m_lvl_n = 0; m_lvl_o = 0; m_p_n = 0; m_p_o = 0; m_pend = 0; m_pwm = 0;
      m_st = 0; m_duty = 0; m_cnt = 0;
   endtask

   task automatic model_edge(input bit n, input bit o);
      bit fn, fo, bnd;
      int tgt, nd, ns;
      q_n.push_back(n);
      q_o.push_back(o);
      fn  = window_flip(q_n, m_lvl_n);
      fo  = window_flip(q_o, m_lvl_o);
      bnd = (m_cnt == P - 1);
      tgt = tgt_of(m_st);
      nd  = m_duty;
      if (bnd) begin
         if (m_pend || m_p_o)   nd = 0;
         else if (m_duty < tgt) nd = (m_duty + RS > tgt) ? tgt : m_duty + RS;
         else if (m_duty > tgt) nd = (m_duty - RS < tgt) ? tgt : m_duty - RS;
      end
      if (m_p_o)      ns = 0;
      else if (m_p_n) ns = (m_st + 1) % 4;
      else            ns = m_st;
      m_pend = bnd ? 1'b0 : (m_p_o ? 1'b1 : m_pend);
      m_pwm  = (m_cnt < m_duty);
      m_cnt  = bnd ? 0 : m_cnt + 1;
      m_duty = nd;
      m_st   = ns;
      m_p_n  = fn && !m_lvl_n;
      m_p_o  = fo && !m_lvl_o;
      if (fn) m_lvl_n = !m_lvl_n;
      if (fo) m_lvl_o = !m_lvl_o;
   endtask

   task automatic tick(input bit n, input bit o);
      @(negedge clk);
      bn = n;
      bo = o;
      @(posedge clk);
      model_edge(n, o);
      #1;
      chk("pwm", int'(pwm), int'(m_pwm));
      chk("state", int'(st), m_st);
      chk("duty", int'(duty), m_duty);
   endtask

   task automatic run(input int len, input bit n, input bit o);
      repeat (len) tick(n, o);
   endtask

   task automatic press(input bit n, input bit o);
      run(DB + 1, n, o);
      run(DB + 1, 1'b0, 1'b0);
   endtask

   task automatic async_reset(input string tag);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk({tag, "_pwm"}, int'(pwm), 0);
      chk({tag, "_state"}, int'(st), 0);
      chk({tag, "_duty"}, int'(duty), 0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      model_reset();
   endtask

   // Align so the next tick returns the first PWM sample of a fresh period.
   task automatic align_period();
      while (m_cnt != 0) tick(bn, bo);
   endtask

   task automatic count_high(input int len, input bit n_len, output int hi);
      hi = 0;
      for (int k = 0; k < len; k++) begin
         tick((k < DB + 1) ? n_len : 1'b0, 1'b0);
         if (pwm === 1'b1) hi++;
      end
   endtask

   initial begin
      int lat, prev, hi;
      bit done;
      model_reset();
      #23;
      chk("rst_pwm", int'(pwm), 0);
      chk("rst_state", int'(st), 0);
      chk("rst_duty", int'(duty), 0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      run(30, 1'b0, 1'b0);
      chk("idle_pwm", int'(pwm), 0);

      // Bouncy press, then clean hold: one press, state changes DB+3 edges after final rise.
      tick(1, 0); tick(0, 0); tick(1, 0); tick(0, 0);
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         tick(1, 0);
         if (st == 2'd1 && lat == 0) lat = k;
      end
      chk("press_latency", lat, DB + 3);
      run(DB + 4, 0, 0);
      chk("single_press_state", int'(st), 1);
      run(3, 1, 0);
      run(DB + 4, 0, 0);
      chk("glitch_state", int'(st), 1);

      // Back to OFF, then three quick next presses to HIGH.
      press(0, 1);
      run(2 * P, 0, 0);
      chk("off_duty", int'(duty), 0);
      press(1, 0); press(1, 0); press(1, 0);
      chk("high_state", int'(st), 3);
      prev = int'(duty);
      for (int k = 0; k < 5 * P && duty != W'(DH); k++) begin
         tick(0, 0);
         if (int'(duty) != prev) begin
            chk("ramp_up_step", int'(duty) - prev, RS);
            prev = int'(duty);
         end
      end
      chk("ramp_up_final", int'(duty), DH);
      align_period();
      count_high(P, 1'b0, hi);
      chk("pwm_high_15", hi, DH);

      // Wrap HIGH -> OFF ramps down one step per period.
      press(1, 0);
      chk("wrap_state", int'(st), 0);
      prev = int'(duty);
      for (int k = 0; k < 5 * P && duty != W'(0); k++) begin
         tick(0, 0);
         if (int'(duty) != prev) begin
            chk("ramp_down_step", prev - int'(duty), RS);
            prev = int'(duty);
         end
      end
      chk("wrap_final", int'(duty), 0);

      // Off priority from MID: duty drops straight to 0.
      press(1, 0); press(1, 0);
      run(3 * P, 0, 0);
      chk("mid_duty", int'(duty), DM);
      press(1, 1);
      chk("both_state", int'(st), 0);
      done = 0;
      for (int k = 0; k < 2 * P && !done; k++) begin
         tick(0, 0);
         if (duty != W'(DM)) begin
            chk("off_jump", int'(duty), 0);
            done = 1;
         end
      end
      chk("off_jump_seen", int'(done), 1);
      align_period();
      count_high(P, 1'b0, hi);
      chk("off_pwm_low", hi, 0);

      // Mid-period next press: current period keeps its duty, next period uses the new one.
      press(1, 0);
      run(2 * P, 0, 0);
      chk("low_duty", int'(duty), DL);
      align_period();
      count_high(P, 1'b1, hi);
      chk("midperiod_same", hi, DL);
      chk("midperiod_state", int'(st), 2);
      count_high(P, 1'b0, hi);
      chk("midperiod_next", hi, DM);

      // Random button activity with a reset in the middle.
      for (int s = 0; s < 80; s++) begin
         bit rn, ro;
         rn = 1'($urandom_range(0, 1));
         ro = ($urandom_range(0, 5) == 0);
         run($urandom_range(1, 2 * DB + 4), rn, ro);
         if (s == 40) async_reset("mid_rst");
      end
      run(4 * P, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
